bin2bcd_seq: RTL and testbench

- Parametrised, sequential binary-to-BCD converter using shift-and-add-3, one bit per clock.
- Produces every decimal digit of an unsigned WIDTH-bit value in a single conversion, not one digit at a time.
- Adds a start/busy/done handshake, an overflow flag and a leading-zero mask.
- Sits between the arithmetic datapath and the 7-segment display driver/multiplexer.

---
 rtl/bcd_pkg.sv | 44 ++++
 rtl/bin2bcd_seq_if.sv | 30 +++
 rtl/bcd_add3.sv | 17 +
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t      : converter FSM encoding (IDLE / SHIFT / DONE)
//   ADD3_THRESH  : digit value at which the shift-and-add-3 correction applies
//   clog2()      : bits needed to count up to a value (counter sizing)
//   min_digits() : decimal digits needed to show 2^width-1
// -----------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] ADD3_THRESH = 4'd5;

   // Smallest r with 2^r >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 40; i++) begin
         if ((longint'(1) << r) < longint'(value)) r = r + 1;
      end
      return r;
   endfunction

   // Number of decimal digits of the largest unsigned width-bit value.
   function automatic int min_digits(input int width);
      longint unsigned m;
      int              d;
      m = (64'd1 << width) - 64'd1;
      d = 1;
      for (int i = 0; i < 24; i++) begin
         if (m >= 64'd10) begin
            m = m / 64'd10;
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_if
// Request/result bundle of the binary-to-BCD converter.
//   start, bin_in                 : requester -> converter
//   busy, done, bcd_out, digit_en,
//   overflow                      : converter -> requester / display driver
// master modport = requester side, slave modport = converter side.
// -----------------------------------------------------------------------------
interface bin2bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [DIGITS-1:0]     digit_en;
   logic                  overflow;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, digit_en, overflow
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, digit_en, overflow
   );
endinterface

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit corrector: digits 5..9 get +3 so the
// following left shift carries into the next decade correctly.
//   i_d : working BCD digit (0..9)
//   o_d : corrected digit (fits in 4 bits since only 5..9 are adjusted)
// -----------------------------------------------------------------------------
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [3:0] i_d,
   output logic [3:0] o_d
);

   assign o_d = (i_d >= ADD3_THRESH) ? (i_d + 4'd3) : i_d;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// All DIGITS decimal digits come out together at the end of a conversion.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.start  : request; accepted only in IDLE or DONE
//   bus.bin_in : value captured on the accepting edge
//   bus.busy   : conversion in progress
//   bus.done   : one-cycle pulse, result registers updated on its rising edge
//   bus.bcd_out, bus.digit_en, bus.overflow : held until the next done
// -----------------------------------------------------------------------------
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   bin2bcd_seq_if.slave   bus
);

   localparam int CW = clog2(WIDTH + 1);
   // With enough digits for 2^WIDTH-1 the top digit can never carry out.
   localparam bit OVF_POSSIBLE = (DIGITS < min_digits(WIDTH));

   state_t                  r_state, w_state_nxt;
   logic [CW-1:0]           r_cnt;
   logic [WIDTH-1:0]        r_bin;
   logic [DIGITS-1:0][3:0]  r_bcd;
   logic                    r_ovf_acc;

   logic [DIGITS-1:0][3:0]  w_adj;
   logic [DIGITS-1:0][3:0]  w_bcd_nxt;
   logic [WIDTH-1:0]        w_bin_nxt;
   logic                    w_carry;
   logic                    w_accept;
   logic                    w_last;
   logic [DIGITS-1:0]       w_digit_en;

   logic [DIGITS-1:0][3:0]  r_bcd_out;
   logic [DIGITS-1:0]       r_digit_en;
   logic                    r_overflow;

   // Per-digit correction ahead of the shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_d (r_bcd[g]),
         .o_d (w_adj[g])
      );
   end

   // One shift step of {bcd, bin}; w_carry is the bit leaving the top digit.
   assign {w_carry, w_bcd_nxt, w_bin_nxt} = {w_adj, r_bin, 1'b0};

   assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CW'(1));

   // Leading-zero mask of the final digits: running OR from the top digit down.
   always_comb begin
      logic v_any;
      w_digit_en = '0;
      v_any      = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_any         = v_any | (w_bcd_nxt[i] != 4'd0);
         w_digit_en[i] = v_any;
      end
      w_digit_en[0] = 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Working shift register, bit counter and overflow accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_ovf_acc <= 1'b0;
      end else if (w_accept) begin
         r_cnt     <= CW'(WIDTH);
         r_bin     <= bus.bin_in;
         r_bcd     <= '0;
         r_ovf_acc <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
         r_cnt     <= r_cnt - CW'(1);
         r_bin     <= w_bin_nxt;
         r_bcd     <= w_bcd_nxt;
         r_ovf_acc <= r_ovf_acc | w_carry;
      end
   end

   // Result registers: loaded from the final shift step, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd_out  <= '0;
         r_digit_en <= DIGITS'(1);
         r_overflow <= 1'b0;
      end else if (w_last) begin
         r_bcd_out  <= w_bcd_nxt;
         r_digit_en <= w_digit_en;
         r_overflow <= OVF_POSSIBLE && (r_ovf_acc || w_carry);
      end
   end

   assign bus.busy     = (r_state == ST_SHIFT);
   assign bus.done     = (r_state == ST_DONE);
   assign bus.bcd_out  = r_bcd_out;
   assign bus.digit_en = r_digit_en;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Three converters (8b/3 digits, 8b/2 digits, 16b/5 digits) on one clock.
// A decimal-arithmetic model predicts busy/done/result every cycle; directed
// vectors add literal expectations for the documented cases.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;
   import bcd_pkg::*;

   localparam int N = 3;

   function automatic int wof(input int i);
      return (i == 2) ? 16 : 8;
   endfunction

   function automatic int dof(input int i);
      return (i == 0) ? 3 : ((i == 1) ? 2 : 5);
   endfunction

   logic clk;
   logic rst_n;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if0 ();
   bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) if1 ();
   bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if2 ();

   bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

   // Uniform views of the three instances
   logic        act_start [N];
   logic [63:0] act_bin   [N];
   logic        act_busy  [N];
   logic        act_done  [N];
   logic [63:0] act_bcd   [N];
   logic [15:0] act_en    [N];
   logic        act_ovf   [N];

   assign act_start[0] = if0.start;  assign act_bin[0] = 64'(if0.bin_in);
   assign act_start[1] = if1.start;  assign act_bin[1] = 64'(if1.bin_in);
   assign act_start[2] = if2.start;  assign act_bin[2] = 64'(if2.bin_in);
   assign act_busy[0] = if0.busy;    assign act_done[0] = if0.done;
   assign act_busy[1] = if1.busy;    assign act_done[1] = if1.done;
   assign act_busy[2] = if2.busy;    assign act_done[2] = if2.done;
   assign act_bcd[0] = 64'(if0.bcd_out); assign act_en[0] = 16'(if0.digit_en); assign act_ovf[0] = if0.overflow;
   assign act_bcd[1] = 64'(if1.bcd_out); assign act_en[1] = 16'(if1.digit_en); assign act_ovf[1] = if1.overflow;
   assign act_bcd[2] = 64'(if2.bcd_out); assign act_en[2] = 16'(if2.digit_en); assign act_ovf[2] = if2.overflow;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int              m_cnt  [N];   // cycles of busy left
   bit              m_done [N];
   longint unsigned m_val  [N];
   logic [63:0]     e_bcd  [N];
   logic [15:0]     e_en   [N];
   bit              e_ovf  [N];

   task automatic convert(input int i);
      longint unsigned p, t, tt;
      p = 1;
      for (int d = 0; d < dof(i); d++) p = p * 10;
      t        = m_val[i] % p;
      e_ovf[i] = (m_val[i] >= p);
      e_bcd[i] = '0;
      e_en[i]  = '0;
      tt       = t;
      p        = 1;
      for (int d = 0; d < dof(i); d++) begin
         e_bcd[i] = e_bcd[i] | (64'(tt % 10) << (4 * d));
         tt       = tt / 10;
         e_en[i][d] = (d == 0) || (t >= p);
         p        = p * 10;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            m_cnt[i]  = 0;
            m_done[i] = 1'b0;
            e_bcd[i]  = '0;
            e_en[i]   = 16'd1;
            e_ovf[i]  = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            if (m_cnt[i] > 0) begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                  m_done[i] = 1'b1;
                  convert(i);
               end
            end else if (act_start[i] === 1'b1) begin
               m_val[i] = act_bin[i];
               m_cnt[i] = wof(i);
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         check($sformatf("u%0d_busy", i), 64'(act_busy[i]), 64'(m_cnt[i] > 0));
         check($sformatf("u%0d_done", i), 64'(act_done[i]), 64'(m_done[i]));
         check($sformatf("u%0d_bcd", i),  act_bcd[i], e_bcd[i]);
         check($sformatf("u%0d_en", i),   64'(act_en[i]), 64'(e_en[i]));
         check($sformatf("u%0d_ovf", i),  64'(act_ovf[i]), 64'(e_ovf[i]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Returns at the negedge where done is seen (or after the bound expires).
   task automatic wait_done(input int i);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (act_done[i] === 1'b1) seen = 1'b1;
      end
      if (!seen) check($sformatf("u%0d_done_timeout", i), 64'd0, 64'd1);
      #1;
   endtask

   int c0, c1, c2, c3;
   bit seen_done;

   initial begin
      rst_n = 1'b0;
      if0.start = 1'b0; if0.bin_in = '0;
      if1.start = 1'b0; if1.bin_in = '0;
      if2.start = 1'b0; if2.bin_in = '0;
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst_u%0d_busy", i), 64'(act_busy[i]), 64'd0);
         check($sformatf("rst_u%0d_done", i), 64'(act_done[i]), 64'd0);
         check($sformatf("rst_u%0d_bcd", i),  act_bcd[i], 64'd0);
         check($sformatf("rst_u%0d_en", i),   64'(act_en[i]), 64'd1);
         check($sformatf("rst_u%0d_ovf", i),  64'(act_ovf[i]), 64'd0);
      end
      rst_n = 1'b1;
      tick();

      // 255 / 137 (overflow) / 65535 started together
      if0.bin_in = 8'd255; if1.bin_in = 8'd137; if2.bin_in = 16'd65535;
      if0.start = 1'b1; if1.start = 1'b1; if2.start = 1'b1;
      c0 = cyc;
      tick();
      if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
      wait_done(0);
      check("lat_w8", 64'(cyc - c0), 64'd9);
      check("bcd_255", act_bcd[0], 64'h255);
      check("en_255", 64'(act_en[0]), 64'b111);
      check("ovf_255", 64'(act_ovf[0]), 64'd0);
      check("model_255", e_bcd[0], 64'h255);
      check("done_137", 64'(act_done[1]), 64'd1);
      check("bcd_137", act_bcd[1], 64'h37);
      check("en_137", 64'(act_en[1]), 64'b11);
      check("ovf_137", 64'(act_ovf[1]), 64'd1);
      check("model_ovf_137", 64'(e_ovf[1]), 64'd1);
      wait_done(2);
      check("lat_w16", 64'(cyc - c0), 64'd17);
      check("bcd_65535", act_bcd[2], 64'h65535);
      check("en_65535", 64'(act_en[2]), 64'b11111);

      // 42 clears overflow; 1000 exercises leading-zero mask
      if1.bin_in = 8'd42; if2.bin_in = 16'd1000;
      if1.start = 1'b1; if2.start = 1'b1;
      tick();
      if1.start = 1'b0; if2.start = 1'b0;
      wait_done(2);
      check("bcd_42", act_bcd[1], 64'h42);
      check("ovf_42", 64'(act_ovf[1]), 64'd0);
      check("en_42", 64'(act_en[1]), 64'b11);
      check("bcd_1000", act_bcd[2], 64'h01000);
      check("en_1000", 64'(act_en[2]), 64'b01111);
      check("model_en_1000", 64'(e_en[2]), 64'b01111);

      // Back-to-back 0, 7, 100 with start held
      if0.bin_in = 8'd0; if0.start = 1'b1;
      tick();
      wait_done(0);
      c1 = cyc;
      check("bcd_0", act_bcd[0], 64'h000);
      check("en_0", 64'(act_en[0]), 64'b001);
      if0.bin_in = 8'd7;
      wait_done(0);
      c2 = cyc;
      check("bcd_7", act_bcd[0], 64'h007);
      check("en_7", 64'(act_en[0]), 64'b001);
      check("b2b_gap1", 64'(c2 - c1), 64'd9);
      if0.bin_in = 8'd100;
      wait_done(0);
      c3 = cyc;
      if0.start = 1'b0;
      check("bcd_100", act_bcd[0], 64'h100);
      check("en_100", 64'(act_en[0]), 64'b111);
      check("b2b_gap2", 64'(c3 - c2), 64'd9);
      tick();

      // start and a new bin_in during SHIFT are ignored
      if0.bin_in = 8'd200; if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      tick(); tick();
      if0.bin_in = 8'd55; if0.start = 1'b1;
      tick(); tick();
      if0.start = 1'b0;
      wait_done(0);
      check("bcd_200", act_bcd[0], 64'h200);
      check("en_200", 64'(act_en[0]), 64'b111);
      tick();

      // Reset in the middle of a conversion
      if0.bin_in = 8'd123; if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(act_busy[0]), 64'd0);
      check("abort_done", 64'(act_done[0]), 64'd0);
      check("abort_bcd", act_bcd[0], 64'd0);
      check("abort_en", 64'(act_en[0]), 64'd1);
      check("abort_ovf", 64'(act_ovf[0]), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (act_done[0] === 1'b1) seen_done = 1'b1;
      end
      #1;
      check("abort_no_done", 64'(seen_done), 64'd0);
      if0.bin_in = 8'd99; if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      wait_done(0);
      check("bcd_99", act_bcd[0], 64'h099);
      check("en_99", 64'(act_en[0]), 64'b011);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
